// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants, condition codes and helpers.
// Imported by the memory stage and its sub-modules.
package arm_pkg;

  localparam logic [6:0]  NOP_OPCODE = 7'b0100000;
  localparam logic [31:0] NOP_INSTR  = 32'hE320F000;
  localparam logic [3:0]  LR_ADDR    = 4'd14;

  localparam logic [1:0] CLS_MEM_HI = 2'b11;
  localparam logic [3:0] CLS_LIT_HI = 4'b1000;
  localparam logic [3:0] CLS_BR_HI  = 4'b1001;

  typedef enum logic [3:0] {
    C_EQ = 4'b0000, C_NE = 4'b0001,
    C_CS = 4'b0010, C_CC = 4'b0011,
    C_MI = 4'b0100, C_PL = 4'b0101,
    C_VS = 4'b0110, C_VC = 4'b0111,
    C_HI = 4'b1000, C_LS = 4'b1001,
    C_GE = 4'b1010, C_LT = 4'b1011,
    C_GT = 4'b1100, C_LE = 4'b1101,
    C_AL = 4'b1110, C_NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    WA_RD = 2'b00,
    WA_LR = 2'b01,
    WA_RN = 2'b10
  } w_addr_e;

  // nzcv = {N, Z, C, V}
  function automatic logic cond_passes(
    input logic [3:0] cond,
    input logic [3:0] nzcv
  );
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond_e'(cond))
      C_EQ: return z;
      C_NE: return !z;
      C_CS: return c;
      C_CC: return !c;
      C_MI: return n;
      C_PL: return !n;
      C_VS: return v;
      C_VC: return !v;
      C_HI: return c && !z;
      C_LS: return !c || z;
      C_GE: return n == v;
      C_LT: return n != v;
      C_GT: return !z && (n == v);
      C_LE: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/memory_unit_if.sv
// Execute <-> memory stage bus: instruction in, controls and
// forwarding identities out.
interface memory_unit_if;
  logic [31:0] instr_in;
  logic [6:0]  opcode_in;
  logic        sel_stall;
  logic [3:0]  status;
  logic [31:0] instr_output;
  logic [3:0]  rn_memory;
  logic [3:0]  rd_memory;
  logic [6:0]  opcode_memory;
  logic [1:0]  sel_w_addr1_memory;
  logic        w_en1;
  logic        w_en_ram;
  logic        sel_ram_addr;
  logic        load_pc;
  logic [3:0]  rt_memory_wait;
  logic [6:0]  opcode_memory_wait;

  modport master (
    output instr_in, opcode_in, sel_stall, status,
    input  instr_output, rn_memory, rd_memory,
    input  opcode_memory, sel_w_addr1_memory,
    input  w_en1, w_en_ram, sel_ram_addr, load_pc,
    input  rt_memory_wait, opcode_memory_wait
  );

  modport slave (
    input  instr_in, opcode_in, sel_stall, status,
    output instr_output, rn_memory, rd_memory,
    output opcode_memory, sel_w_addr1_memory,
    output w_en1, w_en_ram, sel_ram_addr, load_pc,
    output rt_memory_wait, opcode_memory_wait
  );
endinterface

// File: rtl/memory_pipeline_unit.sv
// Memory stage register with bubble insertion on flush/stall.
module memory_pipeline_unit
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [6:0]  opcode_in,
  output logic [31:0] instr_q,
  output logic [6:0]  opcode_q
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      instr_q  <= NOP_INSTR;
      opcode_q <= NOP_OPCODE;
    end else begin
      instr_q  <= instr_in;
      opcode_q <= opcode_in;
    end
  end

endmodule

// File: rtl/memory_unit.sv
// Memory stage: condition check, RAM/regfile/PC control decode
// and the one-deep memory-wait register.
module memory_unit
  import arm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  memory_unit_if.slave  bus
);

  logic [6:0] op;
  logic [6:0] op_eff;
  logic       cond_ok;
  logic       active;
  logic       wb;
  w_addr_e    w_sel;

  memory_pipeline_unit u_pipe (
    .clk       (clk),
    .rst       (rst),
    .bubble    (bus.load_pc || bus.sel_stall),
    .instr_in  (bus.instr_in),
    .opcode_in (bus.opcode_in),
    .instr_q   (bus.instr_output),
    .opcode_q  (op)
  );

  assign bus.rn_memory = bus.instr_output[19:16];
  assign bus.rd_memory = bus.instr_output[15:12];
  assign bus.opcode_memory = op_eff;
  assign bus.sel_w_addr1_memory = w_sel;

  always_comb begin
    // NV is only honoured as "always" for data-processing encodings
    if (bus.instr_output[31:28] == 4'b1111)
      cond_ok = !op[6];
    else
      cond_ok = cond_passes(bus.instr_output[31:28], bus.status);
    active = cond_ok && (op != NOP_OPCODE);
    op_eff = active ? op : NOP_OPCODE;
    wb = !bus.instr_output[24] || bus.instr_output[21];
    w_sel = WA_RD;
    bus.w_en1 = 1'b0;
    bus.w_en_ram = 1'b0;
    bus.sel_ram_addr = 1'b0;
    bus.load_pc = 1'b0;
    if (active) begin
      unique case (1'b1)
        !op[6]: bus.w_en1 = 1'b1;
        op[6:5] == CLS_MEM_HI: begin
          bus.w_en1 = wb;
          w_sel = wb ? WA_RN : WA_RD;
          bus.sel_ram_addr = !bus.instr_output[24];
          bus.w_en_ram = !op[4];
        end
        op[6:3] == CLS_LIT_HI: ;
        op[6:3] == CLS_BR_HI: begin
          bus.load_pc = 1'b1;
          if (bus.instr_output[24]) begin
            bus.w_en1 = 1'b1;
            w_sel = WA_LR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rt_memory_wait     <= 4'd0;
      bus.opcode_memory_wait <= NOP_OPCODE;
    end else begin
      bus.rt_memory_wait     <= bus.instr_output[15:12];
      bus.opcode_memory_wait <= op_eff;
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: hand-computed control vectors.
module tb_memory_unit;

  localparam logic [6:0]  NOP_OP = 7'b0100000;
  localparam logic [31:0] NOP_I  = 32'hE320F000;

  localparam logic [6:0] OP_ADD = 7'b0000100;
  localparam logic [6:0] OP_STR = 7'b1100000;
  localparam logic [6:0] OP_LDR = 7'b1110000;
  localparam logic [6:0] OP_LIT = 7'b1000010;
  localparam logic [6:0] OP_BL  = 7'b1001000;

  localparam logic [31:0] I_ADD   = 32'hE0813002;
  localparam logic [31:0] I_ADDEQ = 32'h00813002;
  localparam logic [31:0] I_ADDNV = 32'hF0813002;
  localparam logic [31:0] I_STR   = 32'hE4825004;
  localparam logic [31:0] I_LDR   = 32'hE5921000;
  localparam logic [31:0] I_LDRWB = 32'hE5B21004;
  localparam logic [31:0] I_LIT   = 32'hE59F1008;
  localparam logic [31:0] I_BL    = 32'hEB000010;
  localparam logic [31:0] I_BLNV  = 32'hFB000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  memory_unit_if bus();

  memory_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] i,
                      input logic [6:0] op,
                      input logic stall);
    bus.instr_in  = i;
    bus.opcode_in = op;
    bus.sel_stall = stall;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ctl(input string tag,
                     input logic we1, input logic [1:0] sel,
                     input logic wram, input logic sra,
                     input logic lpc);
    chk({tag, ".w_en1"}, 32'(bus.w_en1), 32'(we1));
    chk({tag, ".sel_w"}, 32'(bus.sel_w_addr1_memory), 32'(sel));
    chk({tag, ".w_en_ram"}, 32'(bus.w_en_ram), 32'(wram));
    chk({tag, ".sel_ram"}, 32'(bus.sel_ram_addr), 32'(sra));
    chk({tag, ".load_pc"}, 32'(bus.load_pc), 32'(lpc));
  endtask

  initial begin
    bus.instr_in  = I_ADD;
    bus.opcode_in = OP_ADD;
    bus.sel_stall = 1'b0;
    bus.status    = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("rst.op", 32'(bus.opcode_memory), 32'(NOP_OP));
    chk("rst.wop", 32'(bus.opcode_memory_wait), 32'(NOP_OP));
    chk("rst.wrt", 32'(bus.rt_memory_wait), 32'd0);
    chk("rst.instr", bus.instr_output, NOP_I);
    ctl("rst", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    step(I_ADD, OP_ADD, 1'b0);
    chk("add.rd", 32'(bus.rd_memory), 32'd3);
    chk("add.rn", 32'(bus.rn_memory), 32'd1);
    chk("add.op", 32'(bus.opcode_memory), 32'(OP_ADD));
    chk("add.instr", bus.instr_output, I_ADD);
    ctl("add", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    step(I_STR, OP_STR, 1'b0);
    chk("add.wop", 32'(bus.opcode_memory_wait), 32'(OP_ADD));
    chk("add.wrt", 32'(bus.rt_memory_wait), 32'd3);
    chk("str.rn", 32'(bus.rn_memory), 32'd2);
    ctl("str", 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);

    step(I_ADDEQ, OP_ADD, 1'b0);
    chk("str.wop", 32'(bus.opcode_memory_wait), 32'(OP_STR));
    chk("str.wrt", 32'(bus.rt_memory_wait), 32'd5);
    chk("addeq0.op", 32'(bus.opcode_memory), 32'(NOP_OP));
    ctl("addeq0", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    bus.status = 4'b0100;
    #1;
    chk("addeq1.op", 32'(bus.opcode_memory), 32'(OP_ADD));
    ctl("addeq1", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    step(I_LDR, OP_LDR, 1'b0);
    chk("addeq1.wop", 32'(bus.opcode_memory_wait), 32'(OP_ADD));
    chk("ldr.op", 32'(bus.opcode_memory), 32'(OP_LDR));
    ctl("ldr", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    step(I_LDRWB, OP_LDR, 1'b0);
    ctl("ldrwb", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);

    step(I_LIT, OP_LIT, 1'b0);
    chk("lit.op", 32'(bus.opcode_memory), 32'(OP_LIT));
    ctl("lit", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    step(I_BL, OP_BL, 1'b0);
    ctl("bl", 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    step(I_ADD, OP_ADD, 1'b0);
    chk("flush.op", 32'(bus.opcode_memory), 32'(NOP_OP));
    chk("flush.instr", bus.instr_output, NOP_I);
    chk("flush.wop", 32'(bus.opcode_memory_wait), 32'(OP_BL));
    ctl("flush", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    step(I_BL, OP_BL, 1'b0);
    step(I_ADD, OP_ADD, 1'b1);
    chk("flushstall.op", 32'(bus.opcode_memory), 32'(NOP_OP));

    step(I_LDR, OP_LDR, 1'b1);
    chk("stall.op", 32'(bus.opcode_memory), 32'(NOP_OP));
    chk("stall.instr", bus.instr_output, NOP_I);
    step(I_LDR, OP_LDR, 1'b0);
    chk("unstall.op", 32'(bus.opcode_memory), 32'(OP_LDR));
    chk("unstall.rd", 32'(bus.rd_memory), 32'd1);

    step(I_ADDNV, OP_ADD, 1'b0);
    chk("nv_dp.op", 32'(bus.opcode_memory), 32'(OP_ADD));
    ctl("nv_dp", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(I_BLNV, OP_BL, 1'b0);
    chk("nv_bl.op", 32'(bus.opcode_memory), 32'(NOP_OP));
    ctl("nv_bl", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    bus.status = 4'b0000;
    step(I_BL, OP_BL, 1'b0);
    chk("bl2.load_pc", 32'(bus.load_pc), 32'd1);
    rst = 1'b1;
    step(I_ADD, OP_ADD, 1'b0);
    chk("rstbr.op", 32'(bus.opcode_memory), 32'(NOP_OP));
    chk("rstbr.wop", 32'(bus.opcode_memory_wait), 32'(NOP_OP));
    chk("rstbr.wrt", 32'(bus.rt_memory_wait), 32'd0);
    ctl("rstbr", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(I_ADD, OP_ADD, 1'b0);
    chk("post.op", 32'(bus.opcode_memory), 32'(OP_ADD));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
